arbitro_sumador8: RTL and testbench



---
 rtl/arbitro_sumador8_if.sv | 48 ++++
 rtl/arbitro_sumador8.sv | 111 +++++++++++
 tb/tb_arbitro_sumador8.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arbitro_sumador8_if.sv
// Request/grant/result bus between the requesting datapaths, the shared
// adder and the arbitro_sumador8 sequencer.
//   master : requester side plus the adder's result outputs
//   slave  : the sequencer
interface arbitro_sumador8_if #(
    parameter int unsigned WIDTH = 8
);
    // requester -> sequencer
    logic             req0;
    logic             req1;
    logic             op0;
    logic             op1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;

    // sequencer -> requester
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] res;
    logic             cout;

    // sequencer <-> adder
    logic             add_enb;
    logic [1:0]       add_modo;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_rci;
    logic [WIDTH-1:0] add_q;
    logic             add_rco;

    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1,
        input  gnt0, gnt1, done0, done1, res, cout,
        input  add_enb, add_modo, add_a, add_b, add_rci,
        output add_q, add_rco
    );

    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1,
        output gnt0, gnt1, done0, done1, res, cout,
        output add_enb, add_modo, add_a, add_b, add_rci,
        input  add_q, add_rco
    );
endinterface

// File: rtl/arbitro_sumador8.sv
// arbitro_sumador8: round-robin sequencer sharing one sumador8 adder between
// two requesters. One operation takes three cycles: grant/latch (IDLE edge),
// ISSUE (adder computes), CAPT (result captured, DONE raised next cycle).
// Optional feature macro: CLR_IDLE_EN -- when defined, the IDLE cycle right
// after a capture drives ADD_MODO=11 so the adder output reads 0 while idle.
module arbitro_sumador8 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset_l,
    arbitro_sumador8_if.slave   bus
);

    localparam logic [1:0] MODO_HOLD = 2'b00;
    localparam logic [1:0] MODO_ADD  = 2'b01;
    localparam logic [1:0] MODO_SUB  = 2'b10;
    localparam logic [1:0] MODO_CLR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2
    } state_t;

    state_t           state;
    logic             ptr;      // port that wins when both request
    logic             owner;    // port holding the current grant

    logic             req0_m_c;
    logic             req1_m_c;
    logic             any_req_c;
    logic             win_c;
    logic             win_op_c;
    logic [WIDTH-1:0] win_a_c;
    logic [WIDTH-1:0] win_b_c;

    // Carry-in is never used by this sequencer.
    assign bus.add_rci = 1'b0;

    // Winner selection; a port's request is ignored while its DONE is high.
    always_comb begin
        req0_m_c  = bus.req0 & ~bus.done0;
        req1_m_c  = bus.req1 & ~bus.done1;
        any_req_c = req0_m_c | req1_m_c;
        win_c     = (req0_m_c & req1_m_c) ? ptr : req1_m_c;
        win_op_c  = win_c ? bus.op1 : bus.op0;
        win_a_c   = win_c ? bus.a1  : bus.a0;
        win_b_c   = win_c ? bus.b1  : bus.b0;
    end

    // Sequencer state, adder drive and result capture, all registered.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state        <= IDLE;
            ptr          <= 1'b0;
            owner        <= 1'b0;
            bus.gnt0     <= 1'b0;
            bus.gnt1     <= 1'b0;
            bus.done0    <= 1'b0;
            bus.done1    <= 1'b0;
            bus.res      <= '0;
            bus.cout     <= 1'b0;
            bus.add_enb  <= 1'b0;
            bus.add_modo <= MODO_HOLD;
            bus.add_a    <= '0;
            bus.add_b    <= '0;
        end else begin
            bus.done0   <= 1'b0;
            bus.done1   <= 1'b0;
            bus.add_enb <= 1'b1;
            case (state)
                IDLE: begin
                    bus.add_modo <= MODO_HOLD;
                    if (any_req_c) begin
                        owner        <= win_c;
                        bus.gnt0     <= ~win_c;
                        bus.gnt1     <= win_c;
                        bus.add_a    <= win_a_c;
                        bus.add_b    <= win_b_c;
                        bus.add_modo <= win_op_c ? MODO_SUB : MODO_ADD;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.add_modo <= MODO_HOLD;
                    state        <= CAPT;
                end
                CAPT: begin
                    bus.res   <= bus.add_q;
                    bus.cout  <= bus.add_rco;
                    bus.done0 <= ~owner;
                    bus.done1 <= owner;
                    bus.gnt0  <= 1'b0;
                    bus.gnt1  <= 1'b0;
                    ptr       <= ~owner;
`ifdef CLR_IDLE_EN
                    bus.add_modo <= MODO_CLR;
`else
                    bus.add_modo <= MODO_HOLD;
`endif
                    state     <= IDLE;
                end
                default: begin
                    bus.add_modo <= MODO_HOLD;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_sumador8.sv
// Self-checking bench for arbitro_sumador8 with a behavioural sumador8 model.
module tb_arbitro_sumador8;

    localparam int unsigned WIDTH = 8;

`ifdef CLR_IDLE_EN
    localparam logic [1:0] IDLE_MODO = 2'b11;
`else
    localparam logic [1:0] IDLE_MODO = 2'b00;
`endif

    typedef struct packed {
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
    } opr_t;

    logic clk = 1'b0;
    logic reset_l = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   exp_ptr = 1'b0;
    logic [8:0] adder_r = '0;

    always #5 clk = ~clk;

    arbitro_sumador8_if #(.WIDTH(WIDTH)) bus ();

    arbitro_sumador8 #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_l (reset_l),
        .bus     (bus)
    );

    // Behavioural sumador8: registers {RCO,Q} when enabled; sub RCO = borrow.
    always @(posedge clk) begin
        if (bus.add_enb === 1'b1) begin
            case (bus.add_modo)
                2'b01: adder_r <= {1'b0, bus.add_a} + {1'b0, bus.add_b} + 9'(bus.add_rci);
                2'b10: adder_r <= {1'b0, bus.add_a} - {1'b0, bus.add_b};
                2'b11: adder_r <= '0;
                default: ;
            endcase
        end
    end
    assign bus.add_q   = adder_r[7:0];
    assign bus.add_rco = adder_r[8];

    // Expected {COUT,RES} from plain integer arithmetic.
    function automatic logic [8:0] ref_op(input opr_t o);
        int r;
        r = o.op ? (int'(o.a) - int'(o.b)) : (int'(o.a) + int'(o.b));
        return {(o.op ? (o.a < o.b) : (r > 255)), 8'(r & 255)};
    endfunction

    function automatic opr_t mk_op(input logic op, input logic [7:0] a, input logic [7:0] b);
        opr_t o;
        o.op = op; o.a = a; o.b = b;
        return o;
    endfunction

    function automatic opr_t rand_op();
        return mk_op(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    endfunction

    function automatic logic gnt_of(input bit p);
        return p ? bus.gnt1 : bus.gnt0;
    endfunction

    function automatic logic done_of(input bit p);
        return p ? bus.done1 : bus.done0;
    endfunction

    task automatic drive(input bit p, input logic req, input opr_t o);
        if (p) begin
            bus.req1 = req; bus.op1 = o.op; bus.a1 = o.a; bus.b1 = o.b;
        end else begin
            bus.req0 = req; bus.op0 = o.op; bus.a0 = o.a; bus.b0 = o.b;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [32:0] all_outs();
        return {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.cout, bus.add_enb,
                bus.add_rci, bus.add_modo, bus.res, bus.add_a, bus.add_b};
    endfunction

    // One isolated operation on port p, checked cycle by cycle.
    task automatic run_single(input bit p, input opr_t o);
        logic [8:0] exp_r;
        exp_r = ref_op(o);
        drive(p, 1'b1, o);
        tick();
        total++;
        if (gnt_of(p) !== 1'b1 || gnt_of(~p) !== 1'b0 || done_of(p) !== 1'b0) begin
            bad++;
            $display("FAIL grant p%0d: gnt0=%b gnt1=%b done=%b, want only gnt%0d", p, bus.gnt0, bus.gnt1, done_of(p), p);
        end
        total++;
        if (bus.add_modo !== (o.op ? 2'b10 : 2'b01) || bus.add_a !== o.a || bus.add_b !== o.b) begin
            bad++;
            $display("FAIL issue p%0d: modo=%b a=%0d b=%0d, want modo=%b a=%0d b=%0d", p, bus.add_modo, bus.add_a, bus.add_b, (o.op ? 2'b10 : 2'b01), o.a, o.b);
        end
        drive(p, 1'b1, rand_op());
        tick();
        total++;
        if (gnt_of(p) !== 1'b1 || bus.add_modo !== 2'b00 || done_of(p) !== 1'b0) begin
            bad++;
            $display("FAIL capt p%0d: gnt=%b modo=%b done=%b, want 1 00 0", p, gnt_of(p), bus.add_modo, done_of(p));
        end
        tick();
        total++;
        if (done_of(p) !== 1'b1 || done_of(~p) !== 1'b0 || gnt_of(p) !== 1'b0 || {bus.cout, bus.res} !== exp_r) begin
            bad++;
            $display("FAIL done p%0d: done=%b gnt=%b cout/res=%h, want done=1 gnt=0 cout/res=%h", p, done_of(p), gnt_of(p), {bus.cout, bus.res}, exp_r);
        end
        total++;
        if (bus.add_modo !== IDLE_MODO) begin
            bad++;
            $display("FAIL idle_modo p%0d: modo=%b, want %b", p, bus.add_modo, IDLE_MODO);
        end
        drive(p, 1'b0, o);
        tick();
        total++;
        if (done_of(p) !== 1'b0 || {bus.cout, bus.res} !== exp_r || bus.add_modo !== 2'b00) begin
            bad++;
            $display("FAIL hold p%0d: done=%b cout/res=%h modo=%b, want 0 %h 00", p, done_of(p), {bus.cout, bus.res}, bus.add_modo, exp_r);
        end
        exp_ptr = ~p;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, mk_op(1'b0, 8'd5, 8'd6));
        drive(1'b1, 1'b0, mk_op(1'b0, 8'd0, 8'd0));
        #2 reset_l = 1'b0;
        tick();
        tick();
        total++;
        if (all_outs() !== 33'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h, want 0", all_outs());
        end
        reset_l = 1'b1;
        exp_ptr = 1'b0;
        tick();
        total++;
        if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_grant: gnt0=%b gnt1=%b, want 1 0", bus.gnt0, bus.gnt1);
        end
        tick();
        tick();
        total++;
        if (bus.done0 !== 1'b1 || bus.res !== 8'd11 || bus.cout !== 1'b0) begin
            bad++;
            $display("FAIL reset_first_op: done0=%b res=%0d cout=%b, want 1 11 0", bus.done0, bus.res, bus.cout);
        end
        drive(1'b0, 1'b0, mk_op(1'b0, 8'd5, 8'd6));
        tick();
        exp_ptr = 1'b1;
    endtask

    task automatic test_add_port0();
        run_single(1'b0, mk_op(1'b0, 8'd17, 8'd3));
    endtask

    task automatic test_port1();
        run_single(1'b1, mk_op(1'b0, 8'd255, 8'd1));
        run_single(1'b1, mk_op(1'b1, 8'd4, 8'd3));
    endtask

    // Both ports keep requesting; service must alternate starting at the pointer.
    task automatic test_back_to_back();
        opr_t pend[2];
        opr_t infl[2];
        int   cnt[2];
        bit   seen[2];
        bit   relaunch[2];
        bit   exp_p;
        int   cyc;
        exp_p = exp_ptr;
        for (int p = 0; p < 2; p++) begin
            pend[p] = rand_op();
            infl[p] = pend[p];
            cnt[p] = 0; seen[p] = 1'b0; relaunch[p] = 1'b0;
            drive(1'(p), 1'b1, pend[p]);
        end
        cyc = 0;
        while (!(cnt[0] == 3 && cnt[1] == 3) && cyc < 60) begin
            tick();
            cyc++;
            for (int p = 0; p < 2; p++) begin
                if (relaunch[p]) begin
                    pend[p] = rand_op();
                    drive(1'(p), 1'b1, pend[p]);
                    relaunch[p] = 1'b0;
                end
            end
            total++;
            if (bus.gnt0 === 1'b1 && bus.gnt1 === 1'b1) begin
                bad++;
                $display("FAIL b2b_dual_grant: cycle %0d both grants high", cyc);
            end
            for (int p = 0; p < 2; p++) begin
                if (gnt_of(1'(p)) === 1'b1 && !seen[p]) begin
                    seen[p] = 1'b1;
                    infl[p] = pend[p];
                    total++;
                    if (bus.add_modo !== (infl[p].op ? 2'b10 : 2'b01) || bus.add_a !== infl[p].a || bus.add_b !== infl[p].b) begin
                        bad++;
                        $display("FAIL b2b_issue p%0d: modo=%b a=%0d b=%0d, want op=%b a=%0d b=%0d", p, bus.add_modo, bus.add_a, bus.add_b, infl[p].op, infl[p].a, infl[p].b);
                    end
                    drive(1'(p), 1'b1, rand_op());
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (done_of(1'(p)) === 1'b1) begin
                    total++;
                    if ({bus.cout, bus.res} !== ref_op(infl[p]) || 1'(p) != exp_p) begin
                        bad++;
                        $display("FAIL b2b_done p%0d: cout/res=%h want %h, expected port %0d", p, {bus.cout, bus.res}, ref_op(infl[p]), exp_p);
                    end
                    exp_p = ~1'(p);
                    cnt[p]++;
                    seen[p] = 1'b0;
                    drive(1'(p), 1'b0, pend[p]);
                    if (cnt[p] < 3) relaunch[p] = 1'b1;
                end
            end
        end
        total++;
        if (cnt[0] != 3 || cnt[1] != 3) begin
            bad++;
            $display("FAIL b2b_timeout: cnt0=%0d cnt1=%0d, want 3 3", cnt[0], cnt[1]);
        end
        exp_ptr = exp_p;
        tick();
    endtask

    // Port 0 raises and withdraws while port 1 owns the adder: nothing happens.
    task automatic test_withdraw();
        opr_t o1;
        o1 = rand_op();
        drive(1'b1, 1'b1, o1);
        tick();
        total++;
        if (bus.gnt1 !== 1'b1) begin
            bad++;
            $display("FAIL wd_grant1: gnt1=%b, want 1", bus.gnt1);
        end
        drive(1'b1, 1'b1, rand_op());
        drive(1'b0, 1'b1, rand_op());
        tick();
        drive(1'b0, 1'b0, rand_op());
        tick();
        total++;
        if (bus.done1 !== 1'b1 || {bus.cout, bus.res} !== ref_op(o1)) begin
            bad++;
            $display("FAIL wd_done1: done1=%b cout/res=%h, want 1 %h", bus.done1, {bus.cout, bus.res}, ref_op(o1));
        end
        drive(1'b1, 1'b0, o1);
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (bus.gnt0 !== 1'b0 || bus.done0 !== 1'b0) begin
                bad++;
                $display("FAIL wd_spurious: cycle %0d gnt0=%b done0=%b, want 0 0", i, bus.gnt0, bus.done0);
            end
        end
        exp_ptr = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            run_single(1'($urandom_range(0, 1)), rand_op());
        end
    endtask

    // Reset during CAPT of port 1: result dropped, pointer back to port 0.
    task automatic test_reset_mid();
        opr_t o0, o1;
        run_single(1'b0, rand_op());
        o1 = rand_op();
        drive(1'b1, 1'b1, o1);
        tick();
        tick();
        reset_l = 1'b0;
        #1;
        total++;
        if (all_outs() !== 33'd0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got %h, want 0", all_outs());
        end
        drive(1'b1, 1'b0, o1);
        tick();
        total++;
        if (bus.done1 !== 1'b0 || bus.res !== 8'd0) begin
            bad++;
            $display("FAIL mid_reset_no_done: done1=%b res=%0d, want 0 0", bus.done1, bus.res);
        end
        reset_l = 1'b1;
        exp_ptr = 1'b0;
        o0 = rand_op();
        o1 = rand_op();
        drive(1'b0, 1'b1, o0);
        drive(1'b1, 1'b1, o1);
        tick();
        total++;
        if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_ptr: gnt0=%b gnt1=%b, want 1 0", bus.gnt0, bus.gnt1);
        end
        tick();
        tick();
        total++;
        if (bus.done0 !== 1'b1 || {bus.cout, bus.res} !== ref_op(o0)) begin
            bad++;
            $display("FAIL mid_reset_done0: done0=%b cout/res=%h, want 1 %h", bus.done0, {bus.cout, bus.res}, ref_op(o0));
        end
        drive(1'b0, 1'b0, o0);
        tick();
        total++;
        if (bus.gnt1 !== 1'b1 || bus.add_modo !== (o1.op ? 2'b10 : 2'b01)) begin
            bad++;
            $display("FAIL mid_reset_grant1: gnt1=%b modo=%b, want 1 op=%b", bus.gnt1, bus.add_modo, o1.op);
        end
        tick();
        tick();
        total++;
        if (bus.done1 !== 1'b1 || {bus.cout, bus.res} !== ref_op(o1)) begin
            bad++;
            $display("FAIL mid_reset_done1: done1=%b cout/res=%h, want 1 %h", bus.done1, {bus.cout, bus.res}, ref_op(o1));
        end
        drive(1'b1, 1'b0, o1);
        tick();
        exp_ptr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add_port0();
        test_port1();
        test_back_to_back();
        test_withdraw();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
